// File: rtl/matvec_pkg.sv
// Shared types and defaults for the matrix-vector job sequencer.
package matvec_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SIZE  = 64;
    localparam int DEF_LAT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_VEC,
        ST_LOAD_MAT,
        ST_COMPUTE,
        ST_DRAIN
    } state_t;

    typedef logic signed [DEF_WIDTH-1:0] elem_t;

endpackage

// File: rtl/matvec_res_streamer.sv
// Captures the datapath result vector and streams it out one element
// per valid/ready handshake.
module matvec_res_streamer
    import matvec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE,
    parameter int IDXW  = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  drain_en,
    input  logic [SIZE*WIDTH-1:0] dp_out_vector,
    input  logic                  res_ready,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDXW-1:0]       res_idx,
    output logic                  res_last,
    output logic                  res_done
);

    logic [SIZE-1:0][WIDTH-1:0] res_buf_q, res_buf_d;
    logic                       res_valid_q, res_valid_d;
    logic [WIDTH-1:0]           res_data_q, res_data_d;
    logic [IDXW-1:0]            res_idx_q, res_idx_d;
    logic                       res_last_q, res_last_d;
    logic [IDXW-1:0]            idx_nxt;
    logic                       hs;

    assign hs      = res_valid_q & res_ready;
    assign idx_nxt = res_idx_q + 1'b1;

    always_comb begin
        res_buf_d   = res_buf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        if (capture) begin
            res_buf_d   = dp_out_vector;
            res_valid_d = 1'b1;
            res_idx_d   = '0;
            res_data_d  = dp_out_vector[WIDTH-1:0];
            res_last_d  = (SIZE == 1);
        end else if (!drain_en) begin
            res_valid_d = 1'b0;
            res_idx_d   = '0;
            res_last_d  = 1'b0;
        end else if (hs) begin
            if (res_last_q) begin
                res_valid_d = 1'b0;
                res_idx_d   = '0;
                res_last_d  = 1'b0;
            end else begin
                res_idx_d  = idx_nxt;
                res_data_d = res_buf_q[idx_nxt];
                res_last_d = (idx_nxt == IDXW'(SIZE - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_buf_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
        end else begin
            res_buf_q   <= res_buf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_last  = res_last_q;
    assign res_done  = hs & res_last_q;

endmodule

// File: rtl/matvec_job_sequencer.sv
// Sequences one matrix-vector job: load vector and matrix into held
// buffers, wait out the datapath latency, then drain the result vector.
module matvec_job_sequencer
    import matvec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE,
    parameter int LAT   = DEF_LAT,
    parameter int IDXW  = $clog2(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reuse_vec,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [WIDTH-1:0]           vec_data,
    input  logic                       vec_last,
    input  logic                       mat_valid,
    output logic                       mat_ready,
    input  logic [SIZE*WIDTH-1:0]      mat_row,
    output logic [SIZE*WIDTH-1:0]      dp_in_vector,
    output logic [SIZE*SIZE*WIDTH-1:0] dp_matrix,
    input  logic [SIZE*WIDTH-1:0]      dp_out_vector,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic [IDXW-1:0]            res_idx,
    output logic                       res_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int WAITW = $clog2(LAT + 2);

    state_t                          state_q, state_d;
    logic [IDXW-1:0]                 cnt_q, cnt_d;
    logic [WAITW-1:0]                wait_q, wait_d;
    logic [SIZE-1:0][WIDTH-1:0]      vec_buf_q, vec_buf_d;
    logic [SIZE-1:0][SIZE*WIDTH-1:0] mat_buf_q, mat_buf_d;
    logic vec_ready_q, vec_ready_d;
    logic mat_ready_q, mat_ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic vec_hs, mat_hs, cnt_last;
    logic capture, drain_en, res_done;

    assign vec_hs   = vec_valid & vec_ready_q;
    assign mat_hs   = mat_valid & mat_ready_q;
    assign cnt_last = (cnt_q == IDXW'(SIZE - 1));
    assign drain_en = (state_q == ST_DRAIN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        vec_buf_d = vec_buf_q;
        mat_buf_d = mat_buf_q;
        err_d     = err_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = reuse_vec ? ST_LOAD_MAT : ST_LOAD_VEC;
                end
            end
            ST_LOAD_VEC: begin
                if (vec_hs) begin
                    vec_buf_d[cnt_q] = vec_data;
                    // vec_last is advisory; the count alone ends the load
                    if (vec_last != cnt_last) err_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_MAT;
                    end
                end
            end
            ST_LOAD_MAT: begin
                if (mat_hs) begin
                    mat_buf_d[cnt_q] = mat_row;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_last) begin
                        cnt_d   = '0;
                        wait_d  = '0;
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (wait_q == WAITW'(LAT)) begin
                    wait_d  = '0;
                    capture = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        vec_ready_d = (state_d == ST_LOAD_VEC);
        mat_ready_d = (state_d == ST_LOAD_MAT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            vec_buf_q   <= '0;
            mat_buf_q   <= '0;
            vec_ready_q <= 1'b0;
            mat_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            vec_buf_q   <= vec_buf_d;
            mat_buf_q   <= mat_buf_d;
            vec_ready_q <= vec_ready_d;
            mat_ready_q <= mat_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    matvec_res_streamer #(
        .WIDTH(WIDTH),
        .SIZE (SIZE),
        .IDXW (IDXW)
    ) u_res (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .drain_en     (drain_en),
        .dp_out_vector(dp_out_vector),
        .res_ready    (res_ready),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .res_last     (res_last),
        .res_done     (res_done)
    );

    assign vec_ready    = vec_ready_q;
    assign mat_ready    = mat_ready_q;
    assign dp_in_vector = vec_buf_q;
    assign dp_matrix    = mat_buf_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
